seg_scan_driver: RTL

Downstream display stage for the N-value adder. Accepts a frame of `DIGITS` pre-encoded 7-segment codes over a valid/ready handshake and time-multiplexes them onto one shared segment bus with one-hot digit enables. A new frame is double-buffered and committed only at a frame boundary, so the display never tears mid-scan.

---
 rtl/seg_scan_driver_pkg.sv | 34 +++
 rtl/seg_scan_driver_if.sv | 21 ++
 rtl/seg_scan_driver_refresh_tick.sv | 37 +++
 rtl/seg_scan_driver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg
// Shared types and constants for the seven-segment display path. The adder
// stage uses seg_encode to turn result digits into segment codes. The scan
// driver uses the seg_t type and the blanking constants.
// Segment order is abcdefg, with 'a' in bit 6. Segments are active-high.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ZERO = 7'b1111110;
  localparam seg_t SEG_OFF  = 7'b0000000;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_t;

  // Decimal digit to segment code. Non-decimal inputs map to a dark digit.
  function automatic seg_t seg_encode(input logic [3:0] digit);
    seg_t code;
    case (digit)
      4'd0:    code = 7'b1111110;
      4'd1:    code = 7'b0110000;
      4'd2:    code = 7'b1101101;
      4'd3:    code = 7'b1111001;
      4'd4:    code = 7'b0110011;
      4'd5:    code = 7'b1011011;
      4'd6:    code = 7'b1011111;
      4'd7:    code = 7'b1110000;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1111011;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if
// Frame handshake between the producer (adder stage) and the scan driver.
//   s_valid : producer offers a frame on s_data
//   s_ready : driver can take a frame this cycle
//   s_data  : DIGITS segment codes; index 0 is the rightmost digit
// Modports:
//   master = producer side
//   slave  = driver side
interface seg_scan_driver_if #(
  parameter int DIGITS = 2
);
  import seg_pkg::*;

  logic               s_valid;
  logic               s_ready;
  seg_t [DIGITS-1:0]  s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/seg_scan_driver_refresh_tick.sv
// refresh_tick
// Per-digit dwell divider for the scan driver. It counts 0..REFRESH_DIV-1
// while enabled. It pulses tick on the last count of each dwell period.
// While disabled the count is held at 0, so the first digit of a new scan
// always gets a full dwell period.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   en   : count enable (parent is scanning)
//   tick : high during the last cycle of a dwell period
module refresh_tick #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (!en || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = en && (div == DIV_LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexes a frame of DIGITS segment codes onto one shared segment
// bus with one-hot digit enables. Incoming frames are double-buffered:
//   - An accepted frame waits in the pending buffer.
//   - It is committed to the displayed frame only at a frame boundary.
//   - This way a scan never mixes digits from two frames.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
// With it, a run of SEG_ZERO codes at the most-significant end is shown
// dark (digit 0 excepted). The digit enable stays asserted for those digits.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   s_if       : frame handshake (slave side)
//   seg        : segment code of the enabled digit
//   an         : one-hot digit enable, bit i drives digit i
//   frame_done : high on the last cycle of each scan frame
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  s_if,
  output seg_t              seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Encodings match scan_state_t in seg_pkg.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  seg_t [DIGITS-1:0] pend;
  seg_t [DIGITS-1:0] active;
  logic              pend_valid;
  logic              state;
  logic [IW-1:0]     idx;

  logic tick;
  logic accept;
  logic wrap;
  logic commit;

  assign s_if.s_ready = !pend_valid;
  assign accept       = s_if.s_valid && !pend_valid;
  assign wrap         = tick && (idx == IDX_LAST);
  // The pending frame moves to the display when leaving IDLE or at a wrap.
  // A frame accepted on a wrap edge is not pending yet, so it waits one frame.
  assign commit       = pend_valid && ((state == ST_IDLE) || wrap);

  refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_SCAN),
    .tick (tick)
  );

  // Input buffer. accept needs an empty buffer and commit needs a full one,
  // so at most one of them can fire on any edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend       <= s_if.s_data;
      pend_valid <= 1'b1;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // Scan sequencing. Once scanning starts, only reset returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      active <= '0;
    end else begin
      if (commit) begin
        active <= pend;
      end
      if (state == ST_IDLE) begin
        if (pend_valid) begin
          state <= ST_SCAN;
          idx   <= '0;
        end
      end else if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // blank[i] is set when digit i and every more-significant digit show zero.
  logic [DIGITS-1:0] blank;
  logic              lead;

  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (active[i] == SEG_ZERO);
      blank[i] = lead;
    end
  end
`endif

  always_comb begin
    seg = SEG_OFF;
    an  = '0;
    if (state == ST_SCAN) begin
      an  = DIGITS'(1) << idx;
`ifdef SEG_SCAN_LZB_EN
      seg = blank[idx] ? SEG_OFF : active[idx];
`else
      seg = active[idx];
`endif
    end
  end

  assign frame_done = wrap;

endmodule
